// File: rtl/majority_pkg.sv
// Shared constants and types for the TMR majority voter.
// Lane indices, lane count and the per-lane flag vector type.
package majority_pkg;

  localparam int LANE_A    = 0;
  localparam int LANE_B    = 1;
  localparam int LANE_C    = 2;
  localparam int NUM_LANES = 3;

  typedef logic [NUM_LANES-1:0] lane_flags_t;

endpackage

// File: rtl/majority_bit.sv
// 1-bit combinational 2-of-3 voter.
// Ports: a, b, c (lane bits), y (majority bit).
module majority_bit (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic y
);

  assign y = (a & b) | (a & c) | (b & c);

endmodule

// File: rtl/majority.sv
// TMR voter: combinational vote y, registered y_q/mismatch/bad_lane,
// optional saturating per-lane counters (MAJORITY_ERR_CNT_EN).
module majority
  import majority_pkg::*;
#(
  parameter int WIDTH = 1,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] y,
  output logic [WIDTH-1:0] y_q,
  output logic             mismatch,
  output logic [2:0]       bad_lane,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] cnt_a,
  output logic [CNT_W-1:0] cnt_b,
  output logic [CNT_W-1:0] cnt_c
);

  logic [WIDTH-1:0] lane [NUM_LANES];
  lane_flags_t      diff_d;
  logic [WIDTH-1:0] vote_q;
  logic             mis_q;
  lane_flags_t      bad_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_vote
    majority_bit u_bit (
      .a (a[i]),
      .b (b[i]),
      .c (c[i]),
      .y (y[i])
    );
  end

  assign lane[LANE_A] = a;
  assign lane[LANE_B] = b;
  assign lane[LANE_C] = c;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_diff
    assign diff_d[l] = |(lane[l] ^ y);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vote_q <= '0;
      mis_q  <= 1'b0;
      bad_q  <= '0;
    end else begin
      vote_q <= y;
      mis_q  <= |diff_d;
      bad_q  <= diff_d;
    end
  end

  assign y_q      = vote_q;
  assign mismatch = mis_q;
  assign bad_lane = bad_q;

`ifdef MAJORITY_ERR_CNT_EN
  for (genvar l = 0; l < NUM_LANES; l++) begin : g_cnt
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Clear wins over increment; all-ones holds (saturates).
    always_comb begin
      cnt_d = cnt_q;
      if (cnt_clr) begin
        cnt_d = '0;
      end else if (diff_d[l] && (cnt_q != '1)) begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

  assign cnt_a = g_cnt[LANE_A].cnt_q;
  assign cnt_b = g_cnt[LANE_B].cnt_q;
  assign cnt_c = g_cnt[LANE_C].cnt_q;
`else
  logic unused_cnt_clr;
  assign unused_cnt_clr = cnt_clr;
  assign cnt_a = '0;
  assign cnt_b = '0;
  assign cnt_c = '0;
`endif

endmodule

// File: tb/tb_majority.sv
// Directed self-checking bench for majority.
// Instances: WIDTH=1/CNT_W=2 and WIDTH=4/CNT_W=8.
module tb_majority;

  logic clk = 1'b0;
  logic clk_en = 1'b0;
  logic rst_n = 1'b0;
  logic cnt_clr = 1'b0;

  logic a1 = 1'b0, b1 = 1'b0, c1 = 1'b0;
  logic y1, yq1, mis1;
  logic [2:0] bad1;
  logic [1:0] ca1, cb1, cc1;

  logic [3:0] a4 = '0, b4 = '0, c4 = '0;
  logic [3:0] y4, yq4;
  logic mis4;
  logic [2:0] bad4;
  logic [7:0] ca4, cb4, cc4;

  int checks = 0;
  int failures = 0;

`ifdef MAJORITY_ERR_CNT_EN
  localparam bit CNT_ON = 1'b1;
`else
  localparam bit CNT_ON = 1'b0;
`endif

  majority #(.WIDTH(1), .CNT_W(2)) u1 (
    .clk(clk), .rst_n(rst_n),
    .a(a1), .b(b1), .c(c1),
    .y(y1), .y_q(yq1),
    .mismatch(mis1), .bad_lane(bad1),
    .cnt_clr(cnt_clr),
    .cnt_a(ca1), .cnt_b(cb1), .cnt_c(cc1)
  );

  majority #(.WIDTH(4), .CNT_W(8)) u4 (
    .clk(clk), .rst_n(rst_n),
    .a(a4), .b(b4), .c(c4),
    .y(y4), .y_q(yq4),
    .mismatch(mis4), .bad_lane(bad4),
    .cnt_clr(cnt_clr),
    .cnt_a(ca4), .cnt_b(cb4), .cnt_c(cc4)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic test_sweep();
    logic [7:0] exp_tab;
    logic [2:0] v;
    exp_tab = 8'b1110_1000;
    for (int i = 0; i < 8; i++) begin
      v = 3'(i);
      {a1, b1, c1} = v;
      #20;
      checks++;
      if (y1 !== exp_tab[i]) begin
        failures++;
        $display("FAIL sweep v=%0d y=%b exp=%b", i, y1, exp_tab[i]);
      end
    end
  endtask

  task automatic test_reset();
    logic [1:0] exp_c;
    rst_n = 1'b0;
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b0;
    a4 = '0; b4 = '0; c4 = '0;
    #1;
    checks++;
    if (y1 !== 1'b1 || yq1 !== 1'b0 || mis1 !== 1'b0 ||
        bad1 !== 3'b000 || cc1 !== 2'd0) begin
      failures++;
      $display("FAIL reset_hold y=%b yq=%b mis=%b bad=%b cc=%0d exp 1 0 0 000 0",
               y1, yq1, mis1, bad1, cc1);
    end
    clk_en = 1'b1;
    #2;
    rst_n = 1'b1;
    edge1();
    exp_c = CNT_ON ? 2'd1 : 2'd0;
    checks++;
    if (yq1 !== 1'b1 || mis1 !== 1'b1 || bad1 !== 3'b100 ||
        cc1 !== exp_c || ca1 !== 2'd0) begin
      failures++;
      $display("FAIL reset_release yq=%b mis=%b bad=%b cc=%0d ca=%0d exp 1 1 100 %0d 0",
               yq1, mis1, bad1, cc1, ca1, exp_c);
    end
  endtask

  task automatic test_width4();
    a4 = 4'b1010; b4 = 4'b1010; c4 = 4'b0110;
    #1;
    checks++;
    if (y4 !== 4'b1010) begin
      failures++;
      $display("FAIL w4_vote1 y=%b exp=1010", y4);
    end
    edge1();
    checks++;
    if (yq4 !== 4'b1010 || bad4 !== 3'b100 || mis4 !== 1'b1) begin
      failures++;
      $display("FAIL w4_reg1 yq=%b bad=%b mis=%b exp 1010 100 1",
               yq4, bad4, mis4);
    end
    a4 = 4'b0001; b4 = 4'b0010; c4 = 4'b0000;
    #1;
    checks++;
    if (y4 !== 4'b0000) begin
      failures++;
      $display("FAIL w4_vote2 y=%b exp=0000", y4);
    end
    edge1();
    checks++;
    if (yq4 !== 4'b0000 || bad4 !== 3'b011 || mis4 !== 1'b1) begin
      failures++;
      $display("FAIL w4_reg2 yq=%b bad=%b mis=%b exp 0000 011 1",
               yq4, bad4, mis4);
    end
    a4 = 4'b0101; b4 = 4'b0101; c4 = 4'b0101;
    edge1();
    checks++;
    if (yq4 !== 4'b0101 || bad4 !== 3'b000 || mis4 !== 1'b0) begin
      failures++;
      $display("FAIL w4_agree yq=%b bad=%b mis=%b exp 0101 000 0",
               yq4, bad4, mis4);
    end
  endtask

  task automatic test_saturate();
    logic [1:0] seq [5];
    logic [1:0] exp_a;
    seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    cnt_clr = 1'b1;
    a1 = 1'b0; b1 = 1'b0; c1 = 1'b0;
    edge1();
    cnt_clr = 1'b0;
    a1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      edge1();
      exp_a = CNT_ON ? seq[i] : 2'd0;
      checks++;
      if (ca1 !== exp_a || bad1 !== 3'b001 || cb1 !== 2'd0) begin
        failures++;
        $display("FAIL sat_%0d ca=%0d bad=%b cb=%0d exp %0d 001 0",
                 i, ca1, bad1, cb1, exp_a);
      end
    end
  endtask

  task automatic test_clr();
    logic [1:0] exp_a;
    cnt_clr = 1'b1;
    edge1();
    checks++;
    if (ca1 !== 2'd0) begin
      failures++;
      $display("FAIL clr ca=%0d exp 0", ca1);
    end
    cnt_clr = 1'b0;
    edge1();
    exp_a = CNT_ON ? 2'd1 : 2'd0;
    checks++;
    if (ca1 !== exp_a) begin
      failures++;
      $display("FAIL clr_resume ca=%0d exp %0d", ca1, exp_a);
    end
  endtask

  task automatic test_async_reset();
    logic [1:0] exp_a;
    a4 = 4'b1111; b4 = 4'b0000; c4 = 4'b1111;
    edge1();
    edge1();
    exp_a = CNT_ON ? 2'd3 : 2'd0;
    checks++;
    if (ca1 !== exp_a || yq4 !== 4'b1111 || bad4 !== 3'b010) begin
      failures++;
      $display("FAIL pre_rst ca=%0d yq4=%b bad4=%b exp %0d 1111 010",
               ca1, yq4, bad4, exp_a);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (yq1 !== 1'b0 || mis1 !== 1'b0 || bad1 !== 3'b000 ||
        ca1 !== 2'd0 || yq4 !== 4'b0000 || mis4 !== 1'b0 ||
        bad4 !== 3'b000 || cb4 !== 8'd0) begin
      failures++;
      $display("FAIL async_rst yq1=%b mis1=%b bad1=%b ca1=%0d yq4=%b mis4=%b bad4=%b cb4=%0d",
               yq1, mis1, bad1, ca1, yq4, mis4, bad4, cb4);
    end
    checks++;
    if (y1 !== 1'b0 || y4 !== 4'b1111) begin
      failures++;
      $display("FAIL rst_vote y1=%b y4=%b exp 0 1111", y1, y4);
    end
    edge1();
    rst_n = 1'b1;
    edge1();
    exp_a = CNT_ON ? 2'd1 : 2'd0;
    checks++;
    if (ca1 !== exp_a || yq4 !== 4'b1111 || bad4 !== 3'b010) begin
      failures++;
      $display("FAIL post_rst ca=%0d yq4=%b bad4=%b exp %0d 1111 010",
               ca1, yq4, bad4, exp_a);
    end
  endtask

  initial begin
    test_sweep();
    test_reset();
    test_width4();
    test_saturate();
    test_clr();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
